// File: rtl/run_ctrl_fsm.sv
// Run controller for the image-processing pipeline. It handles start/stop/pause
// and three run modes (manual, one-shot, repeat), plus a cycle counter and
// done/wrap/err pulses. Every output is either a register or a decode of
// registered state, so no input reaches an output combinationally.
module run_ctrl_fsm #(
    parameter int CNT_W  = 8,
    parameter int MODE_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [MODE_W-1:0] mode,
    input  logic [CNT_W-1:0]  len,
    output logic [1:0]        state,
    output logic              busy,
    output logic [CNT_W-1:0]  cnt,
    output logic              done,
    output logic              wrap,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [MODE_W-1:0] MODE_ONESHOT = MODE_W'(1);
    localparam logic [MODE_W-1:0] MODE_REPEAT  = MODE_W'(2);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic              wrap_q, wrap_d;
    logic              err_q, err_d;

    // Modes 0 and 3 both run open-ended; only one-shot and repeat need a length.
    logic req_timed;
    logic run_timed;
    logic terminal;

    assign req_timed = (mode == MODE_ONESHOT) || (mode == MODE_REPEAT);
    assign run_timed = (mode_q == MODE_ONESHOT) || (mode_q == MODE_REPEAT);
    assign terminal  = run_timed && (cnt_q == (len_q - CNT_W'(1)));

    // State register plus latched run parameters; reset aborts any run at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            len_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    // Next-state, counter and pulse logic; holds by default, pulses default low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        len_d   = len_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // stop and pause have no meaning here; only start is looked at
                if (start) begin
                    if (req_timed && (len == '0)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        mode_d  = mode;
                        len_d   = len;
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_DONE;
                end else if (pause) begin
                    // a pause on the terminal cycle postpones the terminal action
                    state_d = ST_PAUSE;
                end else if (terminal) begin
                    if (mode_q == MODE_ONESHOT) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d  = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_DONE;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // DONE lasts exactly one cycle; a start here is dropped
                state_d = ST_IDLE;
            end
        endcase
    end

    assign state = state_q;
    assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done  = (state_q == ST_DONE);
    assign cnt   = cnt_q;
    assign wrap  = wrap_q;
    assign err   = err_q;

endmodule
